// File: rtl/pm_save_pkg.sv
// pm_save_pkg
//   Shared definitions for the save-image loader: loader state encoding,
//   EEPROM / SD sector geometry, and the helper that turns a mounted image
//   size into a sector count.
package pm_save_pkg;

    localparam int unsigned EEPROM_BYTES  = 8192;
    localparam int unsigned SECTOR_BYTES  = 512;
    localparam int unsigned EEPROM_ADDR_W = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_REQ,
        S_XFER,
        S_DONE
    } save_load_state_t;

    // ceil(size / 512), clamped to max_sect. A partial trailing sector
    // counts as a whole sector so its bytes are still loaded.
    function automatic logic [4:0] sectors_for_size(input logic [63:0] size,
                                                    input logic [4:0]  max_sect);
        logic [55:0] n;
        n = {1'b0, size[63:9]} + 56'(|size[8:0]);
        if (n > 56'(max_sect))
            return max_sect;
        else
            return n[4:0];
    endfunction

endpackage

// File: rtl/eeprom_save_loader.sv
// eeprom_save_loader
//   On every image mount, blanks the whole 8 KiB EEPROM array through its
//   backdoor write port, then streams up to SECTORS sectors of the mounted
//   save image from the SD block interface into it. busy stays high for
//   the whole pass so the top level can hold the CPU in reset.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   img_mounted       single-cycle mount pulse (restarts any pass in flight)
//   img_size[63:0]    image size in bytes, sampled with img_mounted
//   sd_lba[31:0]      requested sector, sd_rd level read request
//   sd_ack            high for the duration of a sector transfer
//   sd_buff_addr/_dout/_wr  sector byte stream (qualified by sd_ack)
//   eeprom_we/_addr/_data   EEPROM backdoor write port
//   busy              high from the cycle after a mount until done
// All outputs are registered.
module eeprom_save_loader
    import pm_save_pkg::*;
#(
    parameter int unsigned SECTORS    = 16,
    parameter logic [7:0]  BLANK_BYTE = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     img_mounted,
    input  logic [63:0]              img_size,
    output logic [31:0]              sd_lba,
    output logic                     sd_rd,
    input  logic                     sd_ack,
    input  logic [8:0]               sd_buff_addr,
    input  logic [7:0]               sd_buff_dout,
    input  logic                     sd_buff_wr,
    output logic                     eeprom_we,
    output logic [EEPROM_ADDR_W-1:0] eeprom_addr,
    output logic [7:0]               eeprom_data,
    output logic                     busy
);

    localparam logic [EEPROM_ADDR_W-1:0] LAST_ADDR = EEPROM_ADDR_W'(EEPROM_BYTES - 1);

    save_load_state_t         state, state_nx;
    logic [EEPROM_ADDR_W-1:0] clr_addr, clr_addr_nx;
    logic [4:0]               sect, sect_nx;
    logic [4:0]               n_sect, n_sect_nx;
    logic [4:0]               sect_inc;

    logic                     sd_rd_nx;
    logic [31:0]              sd_lba_nx;
    logic                     eeprom_we_nx;
    logic [EEPROM_ADDR_W-1:0] eeprom_addr_nx;
    logic [7:0]               eeprom_data_nx;
    logic                     busy_nx;

    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead and registered, so the write port during CLEAR shows the
    // address belonging to the current CLEAR cycle.
    always_comb begin
        state_nx       = state;
        clr_addr_nx    = clr_addr;
        sect_nx        = sect;
        n_sect_nx      = n_sect;
        sd_rd_nx       = sd_rd;
        sd_lba_nx      = sd_lba;
        eeprom_we_nx   = 1'b0;
        eeprom_addr_nx = eeprom_addr;
        eeprom_data_nx = eeprom_data;
        busy_nx        = busy;
        sect_inc       = sect + 5'd1;

        if (img_mounted) begin
            // A mount always wins, including mid-pass: restart the clear.
            state_nx       = S_CLEAR;
            n_sect_nx      = sectors_for_size(img_size, 5'(SECTORS));
            clr_addr_nx    = '0;
            sect_nx        = '0;
            sd_rd_nx       = 1'b0;
            eeprom_we_nx   = 1'b1;
            eeprom_addr_nx = '0;
            eeprom_data_nx = BLANK_BYTE;
            busy_nx        = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    busy_nx = 1'b0;
                end
                S_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        if (n_sect == '0) begin
                            state_nx = S_DONE;
                        end else begin
                            state_nx  = S_REQ;
                            sd_rd_nx  = 1'b1;
                            sd_lba_nx = 32'(sect);
                        end
                    end else begin
                        clr_addr_nx    = clr_addr + 1'b1;
                        eeprom_we_nx   = 1'b1;
                        eeprom_addr_nx = clr_addr + 1'b1;
                        eeprom_data_nx = BLANK_BYTE;
                    end
                end
                S_REQ: begin
                    if (sd_ack) begin
                        state_nx = S_XFER;
                        sd_rd_nx = 1'b0;
                    end
                end
                S_XFER: begin
                    if (!sd_ack) begin
                        sect_nx = sect_inc;
                        if (sect_inc == n_sect || sect_inc >= 5'(SECTORS)) begin
                            state_nx = S_DONE;
                        end else begin
                            state_nx  = S_REQ;
                            sd_rd_nx  = 1'b1;
                            sd_lba_nx = 32'(sect_inc);
                        end
                    end else if (sd_buff_wr) begin
                        eeprom_we_nx   = 1'b1;
                        eeprom_addr_nx = {sect[3:0], sd_buff_addr};
                        eeprom_data_nx = sd_buff_dout;
                    end
                end
                S_DONE: begin
                    // busy is held through DONE and drops on the IDLE cycle.
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            clr_addr    <= '0;
            sect        <= '0;
            n_sect      <= '0;
            sd_rd       <= 1'b0;
            sd_lba      <= '0;
            eeprom_we   <= 1'b0;
            eeprom_addr <= '0;
            eeprom_data <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            clr_addr    <= clr_addr_nx;
            sect        <= sect_nx;
            n_sect      <= n_sect_nx;
            sd_rd       <= sd_rd_nx;
            sd_lba      <= sd_lba_nx;
            eeprom_we   <= eeprom_we_nx;
            eeprom_addr <= eeprom_addr_nx;
            eeprom_data <= eeprom_data_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_eeprom_save_loader.sv
// tb_eeprom_save_loader
//   Directed bench for eeprom_save_loader: an SD sector responder returning
//   byte = lba ^ buff_addr[7:0], a shadow EEPROM array fed from the write
//   port, and a linear sequence of mount / abort / reset scenarios.
module tb_eeprom_save_loader;
    import pm_save_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        img_mounted;
    logic [63:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic        eeprom_we;
    logic [12:0] eeprom_addr;
    logic [7:0]  eeprom_data;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    eeprom_save_loader #(.SECTORS(16), .BLANK_BYTE(8'hFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .eeprom_we    (eeprom_we),
        .eeprom_addr  (eeprom_addr),
        .eeprom_data  (eeprom_data),
        .busy         (busy)
    );

    // Shadow EEPROM and activity counters, sampled on the falling edge.
    logic [7:0]  rom [0:8191];
    logic [31:0] req_lba [0:255];
    int unsigned wr_cnt, req_cnt, busy_cnt;
    logic        rd_prev;

    initial begin
        for (int unsigned i = 0; i < 8192; i++) rom[i] = 8'h00;
        wr_cnt = 0; req_cnt = 0; busy_cnt = 0; rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (eeprom_we === 1'b1) begin
                rom[eeprom_addr] = eeprom_data;
                wr_cnt++;
            end
            if (sd_rd === 1'b1 && rd_prev !== 1'b1) begin
                req_lba[req_cnt[7:0]] = sd_lba;
                req_cnt++;
            end
            rd_prev = sd_rd;
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // SD responder: two-cycle ack latency, 512 back-to-back strobes, then a
    // stray strobe with sd_ack already low that must not be written.
    initial begin
        logic [31:0] lba;
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
        forever begin
            @(negedge clk);
            if (sd_rd === 1'b1 && sd_ack == 1'b0) begin
                lba = sd_lba;
                repeat (2) @(negedge clk);
                sd_ack = 1'b1;
                for (int unsigned i = 0; i < 512; i++) begin
                    @(negedge clk);
                    sd_buff_addr = 9'(i);
                    sd_buff_dout = lba[7:0] ^ 8'(i);
                    sd_buff_wr   = 1'b1;
                end
                @(negedge clk);
                sd_ack       = 1'b0;
                sd_buff_addr = 9'h1FF;
                sd_buff_dout = 8'h5A;
                @(negedge clk);
                sd_buff_wr   = 1'b0;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int unsigned budget, output logic ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            step();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic mount(input logic [63:0] size);
        img_size    = size;
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
    endtask

    function automatic int unsigned count_nonff(input int unsigned lo, input int unsigned hi);
        int unsigned n = 0;
        for (int unsigned a = lo; a <= hi; a++)
            if (rom[a] !== 8'hFF) n++;
        return n;
    endfunction

    initial begin
        int unsigned wb, rb, bb, bad;
        logic ok;

        reset = 1'b1; img_mounted = 1'b0; img_size = '0;
        repeat (3) step();
        chk("rst_sd_rd",  64'(sd_rd), 64'd0);
        chk("rst_sd_lba", 64'(sd_lba), 64'd0);
        chk("rst_we",     64'(eeprom_we), 64'd0);
        chk("rst_addr",   64'(eeprom_addr), 64'd0);
        chk("rst_data",   64'(eeprom_data), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);
        reset = 1'b0;
        step();

        // img_size = 0: clear only
        wb = wr_cnt; rb = req_cnt; bb = busy_cnt;
        img_size = 64'd0; img_mounted = 1'b1;
        chk("t0_busy_before_edge", 64'(busy), 64'd0);
        step();
        img_mounted = 1'b0;
        chk("t0_busy_rise", 64'(busy), 64'd1);
        chk("t0_first_we",  64'(eeprom_we), 64'd1);
        chk("t0_first_addr", 64'(eeprom_addr), 64'd0);
        chk("t0_first_data", 64'(eeprom_data), 64'hFF);
        wait_idle(9000, ok);
        chk("t0_done", 64'(ok), 64'd1);
        chk("t0_writes", 64'(wr_cnt - wb), 64'd8192);
        chk("t0_reqs", 64'(req_cnt - rb), 64'd0);
        chk("t0_busy_cycles", 64'(busy_cnt - bb), 64'd8194);
        chk("t0_all_ff", 64'(count_nonff(0, 8191)), 64'd0);

        // img_size = 8192: full image
        wb = wr_cnt; rb = req_cnt;
        mount(64'd8192);
        wait_idle(20000, ok);
        chk("t8k_done", 64'(ok), 64'd1);
        chk("t8k_reqs", 64'(req_cnt - rb), 64'd16);
        bad = 0;
        for (int unsigned i = 0; i < 16; i++)
            if (req_lba[8'(rb + i)] !== 32'(i)) bad++;
        chk("t8k_lba_order", 64'(bad), 64'd0);
        chk("t8k_writes", 64'(wr_cnt - wb), 64'd16384);
        chk("t8k_rom_1A05", 64'(rom[13'h1A05]), 64'h08);
        chk("t8k_rom_0000", 64'(rom[13'h0000]), 64'h00);
        chk("t8k_rom_03FF", 64'(rom[13'h03FF]), 64'hFE);
        chk("t8k_rom_1FFF", 64'(rom[13'h1FFF]), 64'hF0);

        // img_size = 700: two sectors, trailing partial sector loaded whole
        wb = wr_cnt; rb = req_cnt;
        mount(64'd700);
        wait_idle(12000, ok);
        chk("t700_done", 64'(ok), 64'd1);
        chk("t700_reqs", 64'(req_cnt - rb), 64'd2);
        chk("t700_lba1", 64'(req_lba[8'(rb + 1)]), 64'd1);
        chk("t700_writes", 64'(wr_cnt - wb), 64'd9216);
        chk("t700_rom_0205", 64'(rom[13'h0205]), 64'h04);
        chk("t700_rom_02BC", 64'(rom[13'h02BC]), 64'hBD);
        chk("t700_rom_03FF", 64'(rom[13'h03FF]), 64'hFE);
        chk("t700_tail_ff", 64'(count_nonff(13'h0400, 13'h1FFF)), 64'd0);

        // img_size = 65536: clamped to 16 sectors
        wb = wr_cnt; rb = req_cnt;
        mount(64'd65536);
        wait_idle(20000, ok);
        chk("t64k_done", 64'(ok), 64'd1);
        chk("t64k_reqs", 64'(req_cnt - rb), 64'd16);
        chk("t64k_last_lba", 64'(req_lba[8'(rb + 15)]), 64'd15);
        chk("t64k_writes", 64'(wr_cnt - wb), 64'd16384);

        // Remount during sector 3 transfer
        mount(64'd8192);
        ok = 1'b0;
        for (int unsigned i = 0; i < 12000; i++) begin
            step();
            if (sd_ack === 1'b1 && sd_rd === 1'b0 && sd_lba === 32'd3) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tab_reached_sect3", 64'(ok), 64'd1);
        repeat (100) step();
        wb = wr_cnt; rb = req_cnt;
        img_size = 64'd1024; img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        chk("tab_sd_rd_low", 64'(sd_rd), 64'd0);
        chk("tab_clear_we", 64'(eeprom_we), 64'd1);
        chk("tab_clear_addr0", 64'(eeprom_addr), 64'd0);
        chk("tab_clear_data", 64'(eeprom_data), 64'hFF);
        chk("tab_busy", 64'(busy), 64'd1);
        wait_idle(12000, ok);
        chk("tab_done", 64'(ok), 64'd1);
        chk("tab_writes", 64'(wr_cnt - wb), 64'd9216);
        chk("tab_reqs", 64'(req_cnt - rb), 64'd2);
        chk("tab_lba0", 64'(req_lba[8'(rb)]), 64'd0);
        chk("tab_rom_0205", 64'(rom[13'h0205]), 64'h04);
        chk("tab_no_stray", 64'(count_nonff(13'h0400, 13'h1FFF)), 64'd0);

        // Reset mid-CLEAR, then a clean mount
        mount(64'd512);
        repeat (100) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("trst_busy", 64'(busy), 64'd0);
        chk("trst_we", 64'(eeprom_we), 64'd0);
        chk("trst_sd_rd", 64'(sd_rd), 64'd0);
        chk("trst_state", 64'(dut.state), 64'(S_IDLE));
        repeat (3) step();
        chk("trst_stays_idle", 64'(busy), 64'd0);
        wb = wr_cnt; rb = req_cnt;
        mount(64'd512);
        wait_idle(10000, ok);
        chk("trst_done", 64'(ok), 64'd1);
        chk("trst_writes", 64'(wr_cnt - wb), 64'd8704);
        chk("trst_reqs", 64'(req_cnt - rb), 64'd1);
        chk("trst_rom_0010", 64'(rom[13'h0010]), 64'h10);
        chk("trst_rom_0200", 64'(rom[13'h0200]), 64'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
